// File: rtl/br_resolver.sv
// br_resolver: execute-side branch resolution queue.
// Fetch pushes one entry per predicted branch/JAL; execute resolves the oldest
// entry in order, and a mismatch produces a registered one-cycle mispredict
// pulse, a redirect PC and a full flush of the in-flight queue.
// Optional build macro BR_RESOLVER_STATS_EN adds saturating resolve/miss counters.
module br_resolver #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid_i,
    input  logic             push_pred_i,
    input  logic [31:0]      push_pc_i,
    input  logic [31:0]      push_target_i,
    output logic             full_o,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    input  logic [31:0]      resolve_target_i,
    output logic             miss_pred_o,
    output logic [31:0]      redirect_pc_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o,
    output logic             err_o,
    output logic [31:0]      resolved_cnt_o,
    output logic [31:0]      miss_cnt_o
);

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] target;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             miss_pred_q, miss_pred_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             err_q, err_d;

    logic             push_acc;
    logic             res_act;
    logic             mp;
    entry_t           head;
    logic [31:0]      redirect_val;

    assign full_o        = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign miss_pred_o   = miss_pred_q;
    assign redirect_pc_o = redirect_pc_q;
    assign err_o         = err_q;

    // Head compare: mispredict detection and the corrected next PC.
    always_comb begin
        push_acc     = push_valid_i && !full_o;
        res_act      = resolve_valid_i && !empty_o;
        head         = mem_q[rd_ptr_q];
        mp           = res_act &&
                       ((head.pred != resolve_taken_i) ||
                        (head.pred && resolve_taken_i && (head.target != resolve_target_i)));
        redirect_val = resolve_taken_i ? resolve_target_i : (head.pc + 32'd4);
    end

    // Queue pointers, occupancy, pulse and sticky error; a mispredict flushes
    // everything and discards a same-cycle (wrong-path) push.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        miss_pred_d   = 1'b0;
        redirect_pc_d = redirect_pc_q;
        err_d         = err_q | (resolve_valid_i && empty_o);
        if (mp) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            miss_pred_d   = 1'b1;
            redirect_pc_d = redirect_val;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (res_act)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_acc && !res_act)      count_d = count_q + (PTR_W+1)'(1);
            else if (!push_acc && res_act) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Entry storage write; wrong-path pushes never land.
    always_comb begin
        mem_d = mem_q;
        if (push_acc && !mp) begin
            mem_d[wr_ptr_q] = '{pred: push_pred_i, pc: push_pc_i, target: push_target_i};
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            miss_pred_q   <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            miss_pred_q   <= miss_pred_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
        end
    end

    // Entry payload needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] resolved_cnt_q, resolved_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        resolved_cnt_d = resolved_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        if (res_act && (resolved_cnt_q != '1)) resolved_cnt_d = resolved_cnt_q + 32'd1;
        if (mp && (miss_cnt_q != '1))          miss_cnt_d     = miss_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resolved_cnt_q <= '0;
            miss_cnt_q     <= '0;
        end else begin
            resolved_cnt_q <= resolved_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign resolved_cnt_o = resolved_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;
`else
    assign resolved_cnt_o = '0;
    assign miss_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_br_resolver.sv
// Directed testbench for br_resolver (DEPTH=4).
module tb_br_resolver;

    localparam int DEPTH = 4;
`ifdef BR_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        push_valid_i, push_pred_i;
    logic [31:0] push_pc_i, push_target_i;
    logic        full_o;
    logic        resolve_valid_i, resolve_taken_i;
    logic [31:0] resolve_target_i;
    logic        miss_pred_o;
    logic [31:0] redirect_pc_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        err_o;
    logic [31:0] resolved_cnt_o, miss_cnt_o;

    int total = 0;
    int bad   = 0;

    br_resolver #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .push_valid_i     (push_valid_i),
        .push_pred_i      (push_pred_i),
        .push_pc_i        (push_pc_i),
        .push_target_i    (push_target_i),
        .full_o           (full_o),
        .resolve_valid_i  (resolve_valid_i),
        .resolve_taken_i  (resolve_taken_i),
        .resolve_target_i (resolve_target_i),
        .miss_pred_o      (miss_pred_o),
        .redirect_pc_o    (redirect_pc_o),
        .empty_o          (empty_o),
        .count_o          (count_o),
        .err_o            (err_o),
        .resolved_cnt_o   (resolved_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic pv, input logic pp, input logic [31:0] ppc, input logic [31:0] pt,
                       input logic rv, input logic rt, input logic [31:0] rtg);
        push_valid_i     = pv;
        push_pred_i      = pp;
        push_pc_i        = ppc;
        push_target_i    = pt;
        resolve_valid_i  = rv;
        resolve_taken_i  = rt;
        resolve_target_i = rtg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        push_valid_i = 0; push_pred_i = 0; push_pc_i = 0; push_target_i = 0;
        resolve_valid_i = 0; resolve_taken_i = 0; resolve_target_i = 0;
        idle();
        idle();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_miss", 32'(miss_pred_o), 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rcnt", resolved_cnt_o, 32'd0);
        chk("rst_mcnt", miss_cnt_o, 32'd0);
        reset_n = 1'b1;

        // Correct taken prediction.
        cyc(1, 1, 32'h100, 32'h0F0, 0, 0, 32'h0);
        chk("t1_count1", 32'(count_o), 32'd1);
        chk("t1_empty0", 32'(empty_o), 32'd0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h0F0);
        chk("t1_nomiss", 32'(miss_pred_o), 32'd0);
        chk("t1_count0", 32'(count_o), 32'd0);
        chk("t1_empty1", 32'(empty_o), 32'd1);

        // Predicted taken, actually not taken; same-cycle push is wrong-path.
        cyc(1, 1, 32'h200, 32'h240, 0, 0, 32'h0);
        cyc(1, 0, 32'h500, 32'h504, 1, 0, 32'h0);
        chk("t2_miss", 32'(miss_pred_o), 32'd1);
        chk("t2_redirect", redirect_pc_o, 32'h204);
        chk("t2_flush_count", 32'(count_o), 32'd0);
        chk("t2_flush_empty", 32'(empty_o), 32'd1);
        idle();
        chk("t2_pulse_end", 32'(miss_pred_o), 32'd0);
        chk("t2_redirect_hold", redirect_pc_o, 32'h204);

        // Predicted not taken, actually taken.
        cyc(1, 0, 32'h300, 32'h304, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h380);
        chk("t3_miss", 32'(miss_pred_o), 32'd1);
        chk("t3_redirect", redirect_pc_o, 32'h380);
        idle();
        chk("t3_pulse_end", 32'(miss_pred_o), 32'd0);

        // Taken both ways but target differs.
        cyc(1, 1, 32'h300, 32'h390, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h380);
        chk("t4_miss", 32'(miss_pred_o), 32'd1);
        chk("t4_redirect", redirect_pc_o, 32'h380);
        chk("t4_rcnt", resolved_cnt_o, STATS ? 32'd4 : 32'd0);
        chk("t4_mcnt", miss_cnt_o, STATS ? 32'd3 : 32'd0);
        idle();

        // Fill: entry i has pc=0x1000+4i, target=0x2000+0x10i, pred=1.
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'h1000 + 32'(4*i), 32'h2000 + 32'(16*i), 0, 0, 32'h0);
        chk("t5_full", 32'(full_o), 32'd1);
        chk("t5_count4", 32'(count_o), 32'd4);
        // Entry 4 pushed while full, with a correct resolve of entry 0: dropped.
        cyc(1, 1, 32'h1010, 32'h2040, 1, 1, 32'h2000);
        chk("t5_drop_count", 32'(count_o), 32'd3);
        chk("t5_drop_full", 32'(full_o), 32'd0);
        chk("t5_drop_nomiss", 32'(miss_pred_o), 32'd0);
        // Push 5..8 while resolving 1,2,3,5: a retained entry 4 would mispredict.
        cyc(1, 1, 32'h1014, 32'h2050, 1, 1, 32'h2010);
        chk("t5_pp1_miss", 32'(miss_pred_o), 32'd0);
        cyc(1, 1, 32'h1018, 32'h2060, 1, 1, 32'h2020);
        chk("t5_pp2_miss", 32'(miss_pred_o), 32'd0);
        cyc(1, 1, 32'h101C, 32'h2070, 1, 1, 32'h2030);
        chk("t5_pp3_miss", 32'(miss_pred_o), 32'd0);
        cyc(1, 1, 32'h1020, 32'h2080, 1, 1, 32'h2050);
        chk("t5_pp4_miss", 32'(miss_pred_o), 32'd0);
        chk("t5_pp_count", 32'(count_o), 32'd3);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h2060);
        chk("t5_d1_count", 32'(count_o), 32'd2);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h2070);
        chk("t5_d2_miss", 32'(miss_pred_o), 32'd0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h2080);
        chk("t5_d3_miss", 32'(miss_pred_o), 32'd0);
        chk("t5_d3_empty", 32'(empty_o), 32'd1);
        chk("t5_redirect_hold", redirect_pc_o, 32'h380);

        // Fall-through PC wraps at the top of the address space.
        cyc(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        chk("t6_miss", 32'(miss_pred_o), 32'd1);
        chk("t6_redirect_wrap", redirect_pc_o, 32'h0);
        idle();

        // Resolve while empty: sticky error, no pulse, not counted.
        chk("t7_err_before", 32'(err_o), 32'd0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        chk("t7_err", 32'(err_o), 32'd1);
        chk("t7_nomiss", 32'(miss_pred_o), 32'd0);
        chk("t7_count", 32'(count_o), 32'd0);
        idle();
        chk("t7_err_sticky", 32'(err_o), 32'd1);
        chk("t7_rcnt", resolved_cnt_o, STATS ? 32'd13 : 32'd0);
        chk("t7_mcnt", miss_cnt_o, STATS ? 32'd4 : 32'd0);

        // Reset overrides a mispredicting resolve and a push with 3 queued.
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h4000 + 32'(4*i), 32'h4004 + 32'(4*i), 0, 0, 32'h0);
        chk("t8_count3", 32'(count_o), 32'd3);
        reset_n = 1'b0;
        cyc(1, 0, 32'h4100, 32'h4104, 1, 1, 32'h9000);
        chk("t8_count", 32'(count_o), 32'd0);
        chk("t8_empty", 32'(empty_o), 32'd1);
        chk("t8_miss", 32'(miss_pred_o), 32'd0);
        chk("t8_redirect", redirect_pc_o, 32'h0);
        chk("t8_err", 32'(err_o), 32'd0);
        chk("t8_rcnt", resolved_cnt_o, 32'd0);
        chk("t8_mcnt", miss_cnt_o, 32'd0);
        reset_n = 1'b1;
        idle();
        chk("t8_post_miss", 32'(miss_pred_o), 32'd0);
        chk("t8_post_count", 32'(count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
